// File: rtl/dmem_responder.sv
// dmem_responder: data-port memory responder with a wait-state FSM over an internal word array.
// Optional feature macro DMEM_POSTED_WRITE_EN: legal writes respond in one cycle via a one-entry buffer.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic [31:0] dmem_address,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wmask,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic        dmem_err,
    output logic        dmem_busy
);
    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CW = 5;
    localparam logic [CW-1:0] WS_LOAD = CW'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] wcnt, wcnt_nxt;
    logic [31:0]   mem [DEPTH_WORDS];

    logic [AW-1:0] req_idx;
    logic [31:0]   req_wdata;
    logic [3:0]    req_wmask;
    logic          req_write;
    logic          req_err;

    logic          req_c, in_range_c, bad_c, post_c, stall_c, resp_fire_c;
    logic [AW-1:0] in_idx_c, cur_idx_c, mem_idx_c;
    logic [31:0]   cur_wdata_c, mem_wdata_c, rd_word_c;
    logic [3:0]    cur_wmask_c, mem_wmask_c;
    logic          cur_write_c, cur_err_c, mem_we_c;
    logic          unused_ok;

    function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                                input logic [31:0] data,
                                                input logic [3:0]  mask);
        logic [31:0] r;
        r = base;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) r[8*b +: 8] = data[8*b +: 8];
        end
        return r;
    endfunction

    assign req_c      = dmem_read | dmem_write;
    assign in_range_c = {2'b00, dmem_address[31:2]} < DEPTH_WORDS;
    assign bad_c      = (dmem_read & dmem_write) | ~in_range_c;
    assign in_idx_c   = dmem_address[AW+1:2];
    assign unused_ok  = &{1'b0, dmem_address[1:0]};

    // In IDLE the live inputs describe the access; afterwards the latched copy does.
    assign cur_idx_c   = (state == IDLE) ? in_idx_c   : req_idx;
    assign cur_wdata_c = (state == IDLE) ? dmem_wdata : req_wdata;
    assign cur_wmask_c = (state == IDLE) ? dmem_wmask : req_wmask;
    assign cur_write_c = (state == IDLE) ? dmem_write : req_write;
    assign cur_err_c   = (state == IDLE) ? bad_c      : req_err;

`ifdef DMEM_POSTED_WRITE_EN
    logic          buf_valid;
    logic [AW-1:0] buf_idx;
    logic [31:0]   buf_wdata;
    logic [3:0]    buf_wmask;
    logic [CW-1:0] dcnt;
    logic          buf_load_c, drain_c;

    assign post_c     = dmem_write & ~dmem_read & in_range_c;
    assign buf_load_c = (state == IDLE) & post_c & ~buf_valid;
    assign drain_c    = buf_valid & (dcnt <= CW'(1));

    // Posted-write buffer: commits WAIT_STATES+1 edges after it is loaded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_valid <= 1'b0;
            dcnt      <= '0;
            buf_idx   <= '0;
            buf_wdata <= '0;
            buf_wmask <= '0;
        end else if (buf_load_c) begin
            buf_valid <= 1'b1;
            dcnt      <= CW'(WAIT_STATES + 1);
            buf_idx   <= cur_idx_c;
            buf_wdata <= cur_wdata_c;
            buf_wmask <= cur_wmask_c;
        end else if (drain_c) begin
            buf_valid <= 1'b0;
            dcnt      <= '0;
        end else if (buf_valid) begin
            dcnt <= dcnt - CW'(1);
        end
    end

    assign mem_we_c    = drain_c;
    assign mem_idx_c   = buf_idx;
    assign mem_wdata_c = buf_wdata;
    assign mem_wmask_c = buf_wmask;
    // A read that hits the pending buffer sees its bytes, even on the draining edge.
    assign rd_word_c   = (buf_valid && (buf_idx == cur_idx_c))
                       ? merge_bytes(mem[cur_idx_c], buf_wdata, buf_wmask)
                       : mem[cur_idx_c];
`else
    logic buf_valid;
    assign buf_valid   = 1'b0;
    assign post_c      = 1'b0;
    assign mem_we_c    = rst & resp_fire_c & cur_write_c & ~cur_err_c;
    assign mem_idx_c   = cur_idx_c;
    assign mem_wdata_c = cur_wdata_c;
    assign mem_wmask_c = cur_wmask_c;
    assign rd_word_c   = mem[cur_idx_c];
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        stall_c   = 1'b0;
        case (state)
            IDLE: begin
                if (req_c && post_c) begin
                    if (buf_valid) stall_c   = 1'b1;
                    else           state_nxt = RESP;
                end else if (req_c) begin
                    wcnt_nxt  = WS_LOAD;
                    state_nxt = (WAIT_STATES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                wcnt_nxt = wcnt - CW'(1);
                if (wcnt <= CW'(1)) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign resp_fire_c = (state_nxt == RESP);

    // Request latch and registered response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_idx    <= '0;
            req_wdata  <= '0;
            req_wmask  <= '0;
            req_write  <= 1'b0;
            req_err    <= 1'b0;
            dmem_rdata <= '0;
            dmem_resp  <= 1'b0;
            dmem_err   <= 1'b0;
            dmem_busy  <= 1'b0;
        end else begin
            dmem_resp <= resp_fire_c;
            dmem_err  <= resp_fire_c & cur_err_c;
            dmem_busy <= (state_nxt != IDLE) | stall_c;
            if (resp_fire_c) dmem_rdata <= (cur_err_c | cur_write_c) ? '0 : rd_word_c;
            if (state == IDLE && req_c) begin
                req_idx   <= in_idx_c;
                req_wdata <= dmem_wdata;
                req_wmask <= dmem_wmask;
                req_write <= dmem_write;
                req_err   <= bad_c;
            end
        end
    end

    // Array is deliberately outside reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we_c) mem[mem_idx_c] <= merge_bytes(mem[mem_idx_c], mem_wdata_c, mem_wmask_c);
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized bench for dmem_responder against a behavioural memory/latency model.
// Builds with or without DMEM_POSTED_WRITE_EN.
`timescale 1ns/1ps
module tb_dmem_responder;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned WS    = 2;
`ifdef DMEM_POSTED_WRITE_EN
    localparam bit POSTED = 1'b1;
`else
    localparam bit POSTED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  wmask;
    logic [31:0] rdata;
    logic        resp, err, busy;

    logic        z_rd, z_wr;
    logic [31:0] z_addr, z_wdata;
    logic [3:0]  z_wmask;
    logic [31:0] z_rdata;
    logic        z_resp, z_err, z_busy;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst(rst), .dmem_read(rd), .dmem_write(wr), .dmem_address(addr),
        .dmem_wdata(wdata), .dmem_wmask(wmask), .dmem_rdata(rdata), .dmem_resp(resp),
        .dmem_err(err), .dmem_busy(busy));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst(rst), .dmem_read(z_rd), .dmem_write(z_wr), .dmem_address(z_addr),
        .dmem_wdata(z_wdata), .dmem_wmask(z_wmask), .dmem_rdata(z_rdata), .dmem_resp(z_resp),
        .dmem_err(z_err), .dmem_busy(z_busy));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: word array plus the timing of the one outstanding access.
    logic [31:0] mdl [DEPTH];
    int          exp_req_cyc  = -1;
    int          exp_resp_cyc = -1;
    logic        exp_err      = 1'b0;
    logic [31:0] held_rdata   = '0;
    logic [31:0] new_rdata    = '0;
    int          buf_free_cyc = 0;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
    endtask

    // Per-cycle comparison of the main DUT against the model.
    always @(negedge clk) begin
        logic er;
        if (!rst) begin
            check("rst_resp", {31'b0, resp}, 32'd0);
            check("rst_err", {31'b0, err}, 32'd0);
            check("rst_busy", {31'b0, busy}, 32'd0);
            check("rst_rdata", rdata, 32'd0);
        end else begin
            er = (cyc == exp_resp_cyc);
            check("resp", {31'b0, resp}, {31'b0, er});
            check("busy", {31'b0, busy}, {31'b0, (cyc > exp_req_cyc) && (cyc <= exp_resp_cyc)});
            check("err", {31'b0, err}, {31'b0, er && exp_err});
            check("rdata", rdata, (cyc >= exp_resp_cyc) ? new_rdata : held_rdata);
        end
    end

    // Issue one access at the start of a cycle; returns what the DUT reported at its response.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          output logic [31:0] o_rdata, output logic o_err, output int o_lat);
        int         c, lat, acc;
        logic       bad;
        logic [9:0] ix;
        c   = cyc;
        bad = (r && w) || (a[31:2] >= DEPTH);
        lat = WS + 1;
        if (POSTED && w && !r && !bad) begin
            acc          = (c > buf_free_cyc) ? c : buf_free_cyc;
            lat          = acc - c + 1;
            buf_free_cyc = acc + WS + 2;
        end
        ix         = a[11:2];
        held_rdata = new_rdata;
        if (bad) new_rdata = '0;
        else if (w) begin
            new_rdata = '0;
            for (int b = 0; b < 4; b++) if (m[b]) mdl[ix][8*b +: 8] = d[8*b +: 8];
        end else new_rdata = mdl[ix];
        exp_err      = bad;
        exp_req_cyc  = c;
        exp_resp_cyc = c + lat;
        rd = r; wr = w; addr = a; wdata = d; wmask = m;
        o_lat = -1; o_rdata = '0; o_err = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (resp) begin
                o_lat = cyc - c; o_rdata = rdata; o_err = err;
                break;
            end
        end
        if (o_lat < 0) check("resp_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
    endtask

    task automatic idle(input int n);
        rd = 1'b0; wr = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] o_rd, a;
        logic        o_er;
        int          o_lat, c0, c1, lat1, sel;

        rd = 0; wr = 0; addr = '0; wdata = '0; wmask = '0;
        z_rd = 0; z_wr = 0; z_addr = '0; z_wdata = '0; z_wmask = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_resp", {31'b0, resp}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_err", {31'b0, err}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // Full-word write and read-back
        access(0, 1, 32'h100, 32'hDEADBEEF, 4'hF, o_rd, o_er, o_lat);
        check("wr_lat", o_lat, POSTED ? 32'd1 : 32'd3);
        check("wr_err", {31'b0, o_er}, 32'd0);
        access(1, 0, 32'h100, 32'h0, 4'h0, o_rd, o_er, o_lat);
        check("rd_data", o_rd, 32'hDEADBEEF);
        check("rd_lat", o_lat, 32'd3);

        // Single byte lane
        access(0, 1, 32'h100, 32'h00AA0000, 4'h4, o_rd, o_er, o_lat);
        access(1, 0, 32'h102, 32'h0, 4'h0, o_rd, o_er, o_lat);
        check("lane_data", o_rd, 32'hDEAABEEF);

        // Error cases
        access(1, 0, 32'h1000, 32'h0, 4'h0, o_rd, o_er, o_lat);
        check("oor_err", {31'b0, o_er}, 32'd1);
        check("oor_rdata", o_rd, 32'd0);
        access(1, 1, 32'h100, 32'h0, 4'hF, o_rd, o_er, o_lat);
        check("both_err", {31'b0, o_er}, 32'd1);
        access(1, 0, 32'h100, 32'h0, 4'h0, o_rd, o_er, o_lat);
        check("both_unchanged", o_rd, 32'hDEAABEEF);

        // Back-to-back with the request held across RESP
        c0 = cyc;
        access(1, 0, 32'h100, 32'h0, 4'h0, o_rd, o_er, lat1);
        c1 = cyc;
        access(1, 0, 32'h100, 32'h0, 4'h0, o_rd, o_er, o_lat);
        check("b2b_first", lat1, 32'd3);
        check("b2b_second", c1 + o_lat - c0, 32'd7);

`ifdef DMEM_POSTED_WRITE_EN
        access(0, 1, 32'h40, 32'h12345678, 4'hF, o_rd, o_er, o_lat);
        check("post_lat", o_lat, 32'd1);
        access(1, 0, 32'h40, 32'h0, 4'h0, o_rd, o_er, o_lat);
        check("post_fwd", o_rd, 32'h12345678);
        access(0, 1, 32'h48, 32'hA5A5A5A5, 4'hF, o_rd, o_er, o_lat);
        access(0, 1, 32'h4C, 32'h5A5A5A5A, 4'hF, o_rd, o_er, o_lat);
        check("post_stall_lat", o_lat, 32'd3);
`else
        // Reset dropped while a write waits: it must be abandoned
        access(0, 1, 32'h200, 32'h11111111, 4'hF, o_rd, o_er, o_lat);
        c0 = cyc;
        wr = 1'b1; addr = 32'h200; wdata = 32'h22222222; wmask = 4'hF;
        held_rdata = new_rdata; new_rdata = '0; exp_err = 1'b0;
        exp_req_cyc = c0; exp_resp_cyc = c0 + WS + 1;
        @(posedge clk); #1;
        @(negedge clk); #1;
        rst = 1'b0; wr = 1'b0;
        exp_req_cyc = -1; exp_resp_cyc = -1; held_rdata = '0; new_rdata = '0;
        #1;
        check("abort_resp", {31'b0, resp}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        access(1, 0, 32'h200, 32'h0, 4'h0, o_rd, o_er, o_lat);
        check("abort_keep", o_rd, 32'h11111111);
`endif

        // Zero wait-state instance: responses in cycles 1 and 3
        c0 = cyc;
        z_wr = 1'b1; z_addr = 32'h10; z_wdata = 32'hCAFEF00D; z_wmask = 4'hF;
        @(negedge clk);
        check("ws0_c0_resp", {31'b0, z_resp}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ws0_c1_resp", {31'b0, z_resp}, 32'd1);
        check("ws0_c1_busy", {31'b0, z_busy}, 32'd1);
        check("ws0_c1_err", {31'b0, z_err}, 32'd0);
        @(posedge clk); #1;
        z_wr = 1'b0; z_rd = 1'b1;
        @(negedge clk);
        check("ws0_c2_resp", {31'b0, z_resp}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("ws0_c3_resp", {31'b0, z_resp}, 32'd1);
        check("ws0_c3_rdata", z_rdata, 32'hCAFEF00D);
        check("ws0_cycle", cyc - c0, 32'd3);
        @(posedge clk); #1;
        z_rd = 1'b0;

        // Randomized traffic over a pre-filled window of 64 words
        for (int i = 0; i < 64; i++)
            access(0, 1, 32'h800 + 32'(4 * i), $urandom, 4'hF, o_rd, o_er, o_lat);
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 99));
            a   = 32'h800 + 32'(4 * $urandom_range(0, 63)) + 32'($urandom_range(0, 3));
            if (sel < 40)
                access(0, 1, a, $urandom, 4'($urandom_range(0, 15)), o_rd, o_er, o_lat);
            else if (sel < 80)
                access(1, 0, a, $urandom, 4'($urandom_range(0, 15)), o_rd, o_er, o_lat);
            else if (sel < 90) begin
                a = 32'h1000 | ($urandom & 32'hFFFF_F000) | ($urandom & 32'h0000_0FFF);
                if ($urandom_range(0, 1) == 0) access(1, 0, a, $urandom, 4'hF, o_rd, o_er, o_lat);
                else                           access(0, 1, a, $urandom, 4'hF, o_rd, o_er, o_lat);
            end else
                access(1, 1, a, $urandom, 4'($urandom_range(0, 15)), o_rd, o_er, o_lat);
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined core's data port. It terminates the request the MEM stage issues (address, write data, byte masks) and returns the read word and a one-cycle `dmem_resp` that lets the MEM/WB pipeline register load. It is backed by an internal word array with a parameterised wait-state counter. It is the memory-side model used in core-level simulation and in the FPGA bring-up top.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: number of 32-bit words in the array; word index is `dmem_address[31:2]`.
- `WAIT_STATES`, 2: extra cycles between request acceptance and response (0–15).

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `dmem_read`  in  1  read request; held until `dmem_resp`.
- `dmem_write`  in  1  write request; held until `dmem_resp`.
- `dmem_address`  in  32  byte address; bits [1:0] ignored.
- `dmem_wdata`  in  32  write data, lane-aligned.
- `dmem_wmask`  in  4  byte-lane write enables; bit i writes `wdata[8i+7:8i]`.
- `dmem_rdata`  out  32  full read word, registered; valid when `dmem_resp`=1.
- `dmem_resp`  out  1  one-cycle completion pulse.
- `dmem_err`  out  1  qualifies `dmem_resp`: request was illegal or out of range.
- `dmem_busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- **IDLE**: samples `dmem_read | dmem_write`. On a request, latch address, wdata, wmask and kind. Load `wcnt = WAIT_STATES`. Go to WAIT, or go straight to RESP if `WAIT_STATES`=0.
- **WAIT**: decrement `wcnt`. On the edge where `wcnt`=1, go to RESP.
- **RESP**: `dmem_resp`=1 for exactly one cycle, then return to IDLE.
- The array access occurs on the edge entering RESP:
  - Read: `dmem_rdata` ← `array[idx]`.
  - Write: masked byte-lane update of `array[idx]`; `dmem_rdata` ← 0.
- Error response (`dmem_err`=1 with `dmem_resp`; no array update; `dmem_rdata`=0) when:
  - both `dmem_read` and `dmem_write` are high when sampled, or
  - `idx >= DEPTH_WORDS`.
- Write with `wmask`=0: normal response with no array change.
- Request inputs are sampled only in IDLE. Changes to them during WAIT or RESP are ignored.
- Array contents are not reset and are preserved across `rst`.

## Timing
- Request sampled in cycle 0. `dmem_resp` is high in cycle `WAIT_STATES+1`. The next request can be sampled in cycle `WAIT_STATES+2`.
- The initiator drops or changes its request on the edge that ends the RESP cycle. A still-asserted request in the following IDLE cycle is treated as a new request.
- Reset values: state=IDLE, `wcnt`=0, `dmem_rdata`=0, `dmem_resp`=0, `dmem_err`=0, `dmem_busy`=0.
- Reset asserted mid-transaction aborts it: no response is issued. A pending write is dropped unless its RESP edge has already occurred.
- `dmem_rdata` holds its value until the next access completes.

## Configuration
- `DMEM_POSTED_WRITE_EN` defined:
  - Legal writes skip WAIT and go IDLE→RESP, so `dmem_resp` is high in cycle 1.
  - The write is placed in a one-entry buffer (idx, wmask, wdata). A separate drain counter commits the buffer to the array `WAIT_STATES+1` cycles after it is loaded.
  - A write sampled while the buffer is valid stays in IDLE until the buffer drains. `dmem_busy` is high during that wait.
  - A read whose idx matches the valid buffer returns array bytes overridden by the buffered bytes in the masked lanes.
  - Reset clears the buffer-valid bit.
- Not defined: no buffer; all writes follow the wait-state path described above.

## Test plan
- Reset with `WAIT_STATES`=2: all outputs 0. Write 0xDEADBEEF to 0x100 with wmask 0xF → `dmem_resp` in cycle 3 with `dmem_err`=0. Read 0x100 → `dmem_rdata`=0xDEADBEEF in cycle 3.
- Byte lanes: with 0x100=0xDEADBEEF, write 0x00AA0000 with wmask 0x4, then read 0x102 → 0xDEAABEEF.
- Errors:
  - read of 0x1000 (idx 1024) → `dmem_resp`=1, `dmem_err`=1, `dmem_rdata`=0;
  - read and write both high → error, and the array is unchanged on read-back.
- Back-to-back with request held across RESP: two accesses complete at cycles 3 and 7. `WAIT_STATES`=0: responses at cycles 1 and 3.
- Drop `rst` in WAIT of a write to 0x200 (old value 0x11111111) → no `dmem_resp`, outputs 0, a later read returns 0x11111111.
- With `DMEM_POSTED_WRITE_EN`:
  - write 0x12345678 to 0x40 → resp at cycle 1;
  - an immediate read of 0x40 → 0x12345678 (forwarded);
  - a second write issued before the drain completes → resp delayed until the buffer drains.
